// File: rtl/pipe_ctrl_gen.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_gen
//
// Opcode/flag pipeline with a decoded control word at its output stage.
// Each opcode is accepted with the condition flags that belong to it. It
// travels through DEPTH-1 raw stages. It is decoded as it enters the final
// (output) stage. A fired word with lpc=1 is a taken transfer. A taken
// transfer flushes every younger stage and the word presented that cycle.
//
// Ports
//   clk         in   sole clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   in_valid    in   opcode/flags present
//   in_ready    out  ~stall
//   in_opcode   in   [OPW-1:0] fetched opcode; only [7:0] is decoded
//   in_flags    in   [NFLAG-1:0] condition flags sampled with the opcode
//   stall       in   freezes every stage, the outputs and the counters
//   ctrl_valid  out  control word at the output stage is valid
//   ctrl_fire   out  ctrl_valid & ~stall
//   ctrl_word   out  [11:0] {rd, wr, clr, we, rsel[1:0], sp[1:0], lpc,
//                    pcsel[1:0], 1'b0}
//   flush       out  ctrl_fire & lpc
//   retire_cnt  out  [CNTW-1:0] fired control words (wraps)
//   taken_cnt   out  [CNTW-1:0] fired words with lpc=1 (wraps)
// ---------------------------------------------------------------------------
module pipe_ctrl_gen #(
    parameter int OPW   = 8,
    parameter int NFLAG = 4,
    parameter int DEPTH = 2,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   in_opcode,
    input  logic [NFLAG-1:0] in_flags,
    input  logic             stall,
    output logic             ctrl_valid,
    output logic             ctrl_fire,
    output logic [11:0]      ctrl_word,
    output logic             flush,
    output logic [CNTW-1:0]  retire_cnt,
    output logic [CNTW-1:0]  taken_cnt
);

    // Raw stages ahead of the output stage
    localparam int NS = DEPTH - 1;

    logic [NS-1:0]    stg_valid;
    logic [OPW-1:0]   stg_op    [NS];
    logic [NFLAG-1:0] stg_flags [NS];
    logic [11:0]      dec_word;
    logic             load_valid;

    function automatic logic [11:0] decode(input logic [7:0]       op,
                                           input logic [NFLAG-1:0] flags);
        logic [7:0] fx;
        logic [4:0] hi;
        logic [2:0] lo;
        logic [2:0] sel;
        logic       rd, wr, clr, we, lpc, cond;
        logic [1:0] rsel, sp, pcsel;
        fx            = '0;
        fx[NFLAG-1:0] = flags;
        hi            = op[7:3];
        lo            = op[2:0];
        sel           = 3'(32'(lo) % NFLAG);
        rd = 1'b0; wr = 1'b0; clr = 1'b0; we = 1'b0; lpc = 1'b0; cond = 1'b0;
        rsel = 2'b00; sp = 2'b00; pcsel = 2'b00;
        case (hi)
            5'b00000: begin
                case (lo)
                    3'd1: clr = 1'b1;
                    3'd3: begin lpc = 1'b1; pcsel = 2'b01; end
                    3'd4: begin lpc = 1'b1; pcsel = 2'b11; end
                    3'd5: begin wr = 1'b1; sp = 2'b01; lpc = 1'b1; pcsel = 2'b01; end
                    3'd6: begin wr = 1'b1; sp = 2'b01; lpc = 1'b1; pcsel = 2'b11; end
                    3'd7: begin rd = 1'b1; sp = 2'b10; lpc = 1'b1; pcsel = 2'b10; end
                    default: ;
                endcase
            end
            5'b00001: begin cond = 1'b1; lpc = 1'b1; pcsel = 2'b01; end
            5'b00010: begin
                if (lo == 3'd0) sp = 2'b11;
                else            we = 1'b1;
            end
            5'b00011: we = 1'b1;
            5'b00101: begin cond = 1'b1; lpc = 1'b1; pcsel = 2'b11; end
            5'b00110: begin cond = 1'b1; wr = 1'b1; sp = 2'b01; lpc = 1'b1; pcsel = 2'b01; end
            5'b00111: begin cond = 1'b1; wr = 1'b1; sp = 2'b01; lpc = 1'b1; pcsel = 2'b11; end
            5'b01001: begin cond = 1'b1; rd = 1'b1; sp = 2'b10; lpc = 1'b1; pcsel = 2'b10; end
            5'b00100, 5'b01000, 5'b01010: begin we = 1'b1; rsel = 2'b01; end
            5'b01011: begin we = 1'b1; rsel = 2'b10; end
            5'b01100: begin
                if (lo == 3'd0) begin we = 1'b1; rsel = 2'b01; end
                else            wr = 1'b1;
            end
            5'b01101: begin wr = 1'b1; sp = 2'b01; end
            5'b01110: begin
                if (lo == 3'd0) begin we = 1'b1; rsel = 2'b01; end
                else            begin rd = 1'b1; we = 1'b1; rsel = 2'b11; end
            end
            5'b01111: begin rd = 1'b1; we = 1'b1; rsel = 2'b11; sp = 2'b10; end
            default: begin
                // 1000xxxx..1110xxxx are ALU ops; 1111xxxx decodes to nothing
                if (hi[4] && (hi[4:1] != 4'b1111)) begin
                    we   = 1'b1;
                    rsel = 2'b01;
                end
            end
        endcase
        if (cond && !fx[sel]) return 12'd0;
        return {rd, wr, clr, we, rsel, sp, lpc, pcsel, 1'b0};
    endfunction

    always_comb dec_word = decode(stg_op[NS-1][7:0], stg_flags[NS-1]);

    assign in_ready   = ~stall;
    assign ctrl_fire  = ctrl_valid & ~stall;
    assign flush      = ctrl_fire & ctrl_word[3];
    // A taken transfer turns everything younger into a bubble, including
    // the word offered on in_* during the flushing cycle.
    assign load_valid = stg_valid[NS-1] & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid  <= '0;
            for (int i = 0; i < NS; i++) begin
                stg_op[i]    <= '0;
                stg_flags[i] <= '0;
            end
            ctrl_valid <= 1'b0;
            ctrl_word  <= '0;
        end else if (!stall) begin
            stg_valid[0] <= in_valid & ~flush;
            stg_op[0]    <= in_opcode;
            stg_flags[0] <= in_flags;
            for (int i = 1; i < NS; i++) begin
                stg_valid[i] <= stg_valid[i-1] & ~flush;
                stg_op[i]    <= stg_op[i-1];
                stg_flags[i] <= stg_flags[i-1];
            end
            ctrl_valid <= load_valid;
            ctrl_word  <= load_valid ? dec_word : 12'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt <= '0;
            taken_cnt  <= '0;
        end else begin
            if (ctrl_fire) retire_cnt <= retire_cnt + CNTW'(1);
            if (flush)     taken_cnt  <= taken_cnt + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
module tb_pipe_ctrl_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [9:0] in_opcode = '0;
    logic [3:0] in_flags = '0;
    logic       stall = 1'b0;

    // d0: DEPTH=2 OPW=8 NFLAG=4 CNTW=16
    // d1: DEPTH=3 OPW=10 NFLAG=4 CNTW=16
    // d2: DEPTH=4 OPW=8 NFLAG=3 CNTW=4
    logic        cv [3];
    logic        cf [3];
    logic        fl [3];
    logic        rdy[3];
    logic [11:0] cw [3];
    logic [15:0] rc [3];
    logic [15:0] tc [3];
    logic [3:0]  rc2, tc2;

    always #5 clk = ~clk;

    pipe_ctrl_gen #(.OPW(8), .NFLAG(4), .DEPTH(2), .CNTW(16)) u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_opcode(in_opcode[7:0]), .in_flags(in_flags), .stall(stall),
        .ctrl_valid(cv[0]), .ctrl_fire(cf[0]), .ctrl_word(cw[0]), .flush(fl[0]),
        .retire_cnt(rc[0]), .taken_cnt(tc[0]));

    pipe_ctrl_gen #(.OPW(10), .NFLAG(4), .DEPTH(3), .CNTW(16)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_opcode(in_opcode), .in_flags(in_flags), .stall(stall),
        .ctrl_valid(cv[1]), .ctrl_fire(cf[1]), .ctrl_word(cw[1]), .flush(fl[1]),
        .retire_cnt(rc[1]), .taken_cnt(tc[1]));

    pipe_ctrl_gen #(.OPW(8), .NFLAG(3), .DEPTH(4), .CNTW(4)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
        .in_opcode(in_opcode[7:0]), .in_flags(in_flags[2:0]), .stall(stall),
        .ctrl_valid(cv[2]), .ctrl_fire(cf[2]), .ctrl_word(cw[2]), .flush(fl[2]),
        .retire_cnt(rc2), .taken_cnt(tc2));

    assign rc[2] = {12'd0, rc2};
    assign tc[2] = {12'd0, tc2};

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    int dep [3] = '{2, 3, 4};
    int nfl [3] = '{4, 4, 3};
    int cmod[3] = '{65536, 65536, 16};

    bit         m_v  [3][3];
    logic [7:0] m_op [3][3];
    logic [3:0] m_fl [3][3];
    bit         o_v  [3];
    logic [11:0] o_w [3];
    int         m_rc [3];
    int         m_tc [3];

    // Control word from the opcode table, by opcode value ranges
    function automatic logic [11:0] ref_dec(logic [7:0] op, logic [3:0] f, int nf);
        int o   = int'(op);
        int grp = o / 8;
        int lo  = o % 8;
        bit flag = f[lo % nf];
        bit rd = 0, wr = 0, clr = 0, we = 0, lpc = 0, cond = 0;
        int rsel = 0, sp = 0, pc = 0;
        if (o == 1) clr = 1;
        else if (o == 3 || grp == 1) begin lpc = 1; pc = 1; cond = (grp == 1); end
        else if (o == 4 || grp == 5) begin lpc = 1; pc = 3; cond = (grp == 5); end
        else if (o == 5 || grp == 6) begin wr = 1; sp = 1; lpc = 1; pc = 1; cond = (grp == 6); end
        else if (o == 6 || grp == 7) begin wr = 1; sp = 1; lpc = 1; pc = 3; cond = (grp == 7); end
        else if (o == 7 || grp == 9) begin rd = 1; sp = 2; lpc = 1; pc = 2; cond = (grp == 9); end
        else if (o == 16) sp = 3;
        else if (grp == 2 || grp == 3) we = 1;
        else if (grp == 11) begin we = 1; rsel = 2; end
        else if (o == 96 || o == 112 || grp == 4 || grp == 8 || grp == 10 ||
                 (o >= 128 && o < 240)) begin we = 1; rsel = 1; end
        else if (grp == 12) wr = 1;
        else if (grp == 13) begin wr = 1; sp = 1; end
        else if (grp == 14) begin rd = 1; we = 1; rsel = 3; end
        else if (grp == 15) begin rd = 1; we = 1; rsel = 3; sp = 2; end
        if (cond && !flag) return 12'd0;
        return {rd, wr, clr, we, rsel[1:0], sp[1:0], lpc, pc[1:0], 1'b0};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 3; k++) begin
                m_v[i][k] = 0; m_op[i][k] = '0; m_fl[i][k] = '0;
            end
            o_v[i] = 0; o_w[i] = '0; m_rc[i] = 0; m_tc[i] = 0;
        end
    endtask

    task automatic m_step(bit st, bit v, logic [7:0] op, logic [3:0] f);
        bit taken;
        int last;
        if (st) return;
        for (int i = 0; i < 3; i++) begin
            taken = o_v[i] && o_w[i][3];
            if (o_v[i]) m_rc[i] = (m_rc[i] + 1) % cmod[i];
            if (taken)  m_tc[i] = (m_tc[i] + 1) % cmod[i];
            last = dep[i] - 2;
            if (taken) begin
                for (int k = 0; k < 3; k++) m_v[i][k] = 0;
                o_v[i] = 0;
                o_w[i] = '0;
            end else begin
                o_v[i] = m_v[i][last];
                o_w[i] = m_v[i][last] ? ref_dec(m_op[i][last], m_fl[i][last], nfl[i]) : 12'd0;
                for (int k = last; k > 0; k--) begin
                    m_v[i][k] = m_v[i][k-1]; m_op[i][k] = m_op[i][k-1]; m_fl[i][k] = m_fl[i][k-1];
                end
                m_v[i][0] = v; m_op[i][0] = op; m_fl[i][0] = f;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s d%0d observed=%0h expected=%0h", tag, i, obs, exp);
        end
    endtask

    task automatic chk_all();
        for (int i = 0; i < 3; i++) begin
            chk("ctrl_valid", i, 32'(cv[i]), 32'(o_v[i]));
            chk("ctrl_word",  i, 32'(cw[i]), 32'(o_w[i]));
            chk("ctrl_fire",  i, 32'(cf[i]), 32'(o_v[i] && !stall));
            chk("flush",      i, 32'(fl[i]), 32'(o_v[i] && !stall && o_w[i][3]));
            chk("in_ready",   i, 32'(rdy[i]), 32'(!stall));
            chk("retire_cnt", i, 32'(rc[i]), 32'(m_rc[i]));
            chk("taken_cnt",  i, 32'(tc[i]), 32'(m_tc[i]));
        end
    endtask

    // One clock: drive, compare at negedge, step model at posedge.
    task automatic cycle(bit v, logic [9:0] op, logic [3:0] f, bit st);
        in_valid = v; in_opcode = op; in_flags = f; stall = st;
        @(negedge clk);
        chk_all();
        @(posedge clk);
        m_step(st, v, op[7:0], f);
        #1;
    endtask

    task automatic bubbles(int n);
        for (int k = 0; k < n; k++) cycle(0, 10'h000, 4'h0, 0);
    endtask

    // Asynchronous reset asserted between edges
    task automatic do_reset();
        rst_n = 1'b0;
        m_reset();
        #2;
        for (int i = 0; i < 3; i++) begin
            chk("rst_valid",  i, 32'(cv[i]), 32'd0);
            chk("rst_word",   i, 32'(cw[i]), 32'd0);
            chk("rst_retire", i, 32'(rc[i]), 32'd0);
            chk("rst_taken",  i, 32'(tc[i]), 32'd0);
        end
        #1;
        rst_n = 1'b1;
    endtask

    int r0, t0;

    initial begin
        m_reset();
        #3;
        for (int i = 0; i < 3; i++) begin
            chk("init_valid",  i, 32'(cv[i]), 32'd0);
            chk("init_retire", i, 32'(rc[i]), 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset mid-stream, then 0x80 two edges after acceptance (d0)
        cycle(1, 10'h080, 4'h0, 0);
        cycle(1, 10'h081, 4'h0, 0);
        cycle(1, 10'h082, 4'h0, 0);
        do_reset();
        cycle(1, 10'h080, 4'h0, 0);
        chk("lat2_e1_valid", 0, 32'(cv[0]), 32'd0);
        cycle(0, 10'h000, 4'h0, 0);
        chk("lat2_e2_valid", 0, 32'(cv[0]), 32'd1);
        chk("lat2_e2_word",  0, 32'(cw[0]), 32'h140);

        // Latency and bubbles on DEPTH=4 (d2)
        bubbles(5);
        cycle(1, 10'h001, 4'h0, 0);
        cycle(0, 10'h000, 4'h0, 0);
        cycle(1, 10'h06A, 4'h0, 0);
        chk("lat4_e3_valid", 2, 32'(cv[2]), 32'd0);
        cycle(0, 10'h000, 4'h0, 0);
        chk("lat4_e4_valid", 2, 32'(cv[2]), 32'd1);
        chk("lat4_e4_word",  2, 32'(cw[2]), 32'h200);
        cycle(0, 10'h000, 4'h0, 0);
        chk("lat4_e5_valid", 2, 32'(cv[2]), 32'd0);
        cycle(0, 10'h000, 4'h0, 0);
        chk("lat4_e6_valid", 2, 32'(cv[2]), 32'd1);
        chk("lat4_e6_word",  2, 32'(cw[2]), 32'h410);

        // Conditional JCD sel=1 (d0)
        bubbles(5);
        cycle(1, 10'h009, 4'b0010, 0);
        cycle(0, 10'h000, 4'h0, 0);
        chk("jcd_taken_word",  0, 32'(cw[0]), 32'h00A);
        chk("jcd_taken_flush", 0, 32'(fl[0]), 32'd1);
        cycle(0, 10'h000, 4'h0, 0);
        cycle(1, 10'h009, 4'b0000, 0);
        cycle(0, 10'h000, 4'h0, 0);
        chk("jcd_nt_valid", 0, 32'(cv[0]), 32'd1);
        chk("jcd_nt_word",  0, 32'(cw[0]), 32'h000);
        chk("jcd_nt_flush", 0, 32'(fl[0]), 32'd0);
        r0 = m_rc[0];
        cycle(0, 10'h000, 4'h0, 0);
        chk("jcd_nt_retire", 0, 32'(rc[0]), 32'(r0 + 1));

        // Taken-transfer flush on DEPTH=3 (d1)
        bubbles(2);
        do_reset();
        cycle(1, 10'h004, 4'h0, 0);
        cycle(1, 10'h080, 4'h0, 0);
        cycle(1, 10'h081, 4'h0, 0);
        chk("jua_flush", 1, 32'(fl[1]), 32'd1);
        cycle(1, 10'h082, 4'h0, 0);
        chk("flush_next1", 1, 32'(cv[1]), 32'd0);
        chk("flush_taken", 1, 32'(tc[1]), 32'd1);
        chk("flush_retire", 1, 32'(rc[1]), 32'd1);
        cycle(0, 10'h000, 4'h0, 0);
        chk("flush_next2", 1, 32'(cv[1]), 32'd0);

        // Stall for 5 cycles with CUA at the output (d0)
        bubbles(5);
        cycle(1, 10'h006, 4'h0, 0);
        cycle(0, 10'h000, 4'h0, 0);
        r0 = m_rc[0]; t0 = m_tc[0];
        for (int k = 0; k < 5; k++) begin
            cycle(1, 10'h080, 4'h0, 1);
            chk("stall_valid",  0, 32'(cv[0]), 32'd1);
            chk("stall_word",   0, 32'(cw[0]), 32'h41E);
            chk("stall_fire",   0, 32'(cf[0]), 32'd0);
            chk("stall_ready",  0, 32'(rdy[0]), 32'd0);
            chk("stall_retire", 0, 32'(rc[0]), 32'(r0));
        end
        cycle(0, 10'h000, 4'h0, 0);
        chk("unstall_retire", 0, 32'(rc[0]), 32'(r0 + 1));
        chk("unstall_taken",  0, 32'(tc[0]), 32'(t0 + 1));
        cycle(0, 10'h000, 4'h0, 0);
        chk("unstall_once",   0, 32'(tc[0]), 32'(t0 + 1));

        // Counter wrap with CNTW=4 (d2)
        do_reset();
        for (int k = 0; k < 17; k++) cycle(1, 10'h000, 4'h0, 0);
        bubbles(4);
        chk("wrap_retire", 2, 32'(rc[2]), 32'd1);
        chk("nowrap_retire", 0, 32'(rc[0]), 32'd17);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            cycle(($urandom_range(0, 3) != 0),
                  10'($urandom_range(0, 1023)),
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 4) == 0));
        end
        stall = 1'b0;
        bubbles(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_gen.md
Name: pipe_ctrl_gen

Overview:
- Parametrised successor to the two-stage opcode-latch/control-decode pair.
- Carries opcodes plus a sampled flag vector through a DEPTH-stage valid-tagged pipeline with stall hold and taken-transfer flush.
- Decodes a registered control word at the last stage and counts retired and taken transfers.
- Sits between instruction fetch and the datapath (PC mux, SP, register file, data memory).

Parameters:
- OPW, 8, opcode width; decode uses opcode[7:0], upper bits ignored (OPW>=8).
- NFLAG, 4, number of condition flags sampled with each opcode (1..8).
- DEPTH, 2, pipeline stages from acceptance to control output (>=2).
- CNTW, 16, width of the retire and taken counters.

Ports:
- clk, input, 1, sole clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, opcode/flags present.
- in_ready, output, 1, = ~stall.
- in_opcode, input, OPW, fetched opcode.
- in_flags, input, NFLAG, condition flags, sampled with the opcode.
- stall, input, 1, freezes every stage and the outputs.
- ctrl_valid, output, 1, control word at the output stage is valid.
- ctrl_fire, output, 1, = ctrl_valid & ~stall; the datapath acts only on fire.
- ctrl_word, output, 12, {rd, wr, clr, we, rsel[1:0], sp[1:0], lpc, pcsel[1:0], rsv=0}.
- flush, output, 1, = ctrl_fire & lpc.
- retire_cnt, output, CNTW, count of fired control words.
- taken_cnt, output, CNTW, count of fired words with lpc=1.

Behaviour:
- Reset (async, any time): all stage valids=0; ctrl_valid=0; ctrl_word=0; both counters=0. In-flight work is discarded, and the first edge after release is normal.
- Advance: with stall=0, every stage shifts one position on each edge.
  - Stage 0 loads {in_valid, in_opcode, in_flags}.
  - Accept-to-ctrl_valid latency is exactly DEPTH edges.
  - Bubbles (in_valid=0) propagate as valid=0 with ctrl_word=0.
- Stall=1: every register holds, counters hold, and inputs are not accepted. ctrl_valid stays asserted if already set.
- Decode: performed when the word enters the output stage. Flag sel = opcode[2:0] mod NFLAG, using the flags captured with that opcode. "C" marks a conditional entry that decodes to all-zero when the selected flag=0.
  - 00000000 NOP: 0.
  - 00000001 CLR: clr.
  - 00000011 JUD, 00001xxx JCD(C): lpc, pcsel=01.
  - 00000100 JUA, 00101xxx JCA(C): lpc, pcsel=11.
  - 00000101 CUD, 00110xxx CCD(C): wr, sp=01, lpc, pcsel=01.
  - 00000110 CUA, 00111xxx CCA(C): wr, sp=01, lpc, pcsel=11.
  - 00000111 RTU, 01001xxx RTC(C): rd, sp=10, lpc, pcsel=10.
  - 00010000 LSP: sp=11.
  - 00010xxx / 00011xxx MVD/RSP/MVS: we, rsel=00.
  - 01011xxx MVI: we, rsel=10.
  - 01100xxx (≠01100000) STA: wr.
  - 01101xxx PSH: wr, sp=01.
  - 01110xxx (≠01110000) LDA: rd, we, rsel=11.
  - 01111xxx POP: rd, we, rsel=11, sp=10.
  - 00100xxx, 01000xxx, 01010xxx, 01100000, 01110000, 1000x..1110x ALU: we, rsel=01.
  - 1111xxxx and all other codes: 0.
- Flush: on an edge with flush=1, stages 0..DEPTH-2 valids clear, and the word presented on in_* that cycle is dropped even though in_ready=1. The output stage loads a bubble.
- Counters: retire_cnt+1 per ctrl_fire; taken_cnt+1 per flush. Both wrap 2^CNTW-1 -> 0.
- Simultaneous stall and flush-candidate: no flush until the stall releases. The flush then acts once.

Test Plan:
- Reset mid-stream: DEPTH=2, feed 3 ALU opcodes, assert rst_n=0 between edges -> ctrl_valid=0 and counters=0 immediately; after release, the next opcode 0x80 appears exactly 2 edges after acceptance with word we=1, rsel=01.
- Latency/bubbles: DEPTH=4, feed 0x01, bubble, 0x6A -> ctrl_valid pattern 1,0,1 starting 4 edges after the first accept; words clr, then wr+sp=01.
- Conditional: 0x09 (JCD, sel=1) with flags=4'b0010 -> lpc=1, pcsel=01, flush=1; same opcode with flags=4'b0000 -> word=0, flush=0, retire_cnt still +1.
- Flush: 0x04 followed back-to-back by 0x80, 0x81, 0x82 (DEPTH=3) -> after JUA fires, the next two ctrl_valid cycles are 0; taken_cnt=1, retire_cnt=1.
- Stall: assert stall for 5 cycles with CUA (0x06) at the output -> word held, ctrl_fire=0, in_ready=0, counters frozen; on release, one fire and one flush.
- Wrap: CNTW=4, 17 consecutive NOP fires -> retire_cnt reads 1.
